// File: rtl/ncc_sequencer.sv
// -----------------------------------------------------------------------------
// ncc_sequencer
//
// Purpose:
//   Control FSM for the 16x16 NCC processing-element array. A pass first loads
//   the 256-pixel descriptor into the PE descriptor registers, one 32-bit word
//   (four pixels) at a time. It then streams WIN_COLS window pixels through the
//   array. Each accepted pixel pulses the window-register and accumulator-
//   register loads. The FSM flags each cycle in which the array output holds a
//   valid correlation result.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a pass (only honoured in IDLE)
//   desc_valid      descriptor word available
//   desc_ack        descriptor word consumed this cycle
//   load_desc_now   strobe to the PE descriptor registers
//   load_row        one-hot descriptor row select (zero unless load_desc_now)
//   load_col_grp    one-hot column-group select (zero unless load_desc_now)
//   win_valid       window pixel available
//   win_ready       sequencer accepts window pixels (WIN_STREAM)
//   load_win_reg    shift the window pixel into the array
//   load_acc_reg    load the PE accumulator registers
//   result_valid    array accOut holds a valid result (registered)
//   result_idx      window position of the current result (holds when idle)
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of a pass
//   stall_cycles    count of window-starved cycles in WIN_STREAM
//
// Configuration:
//   NCC_SEQ_STALL_CNT_EN  when defined, builds a saturating 16-bit counter of
//                         WIN_STREAM cycles with win_valid low. When undefined,
//                         stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module ncc_sequencer #(
  parameter int ROWS       = 16,
  parameter int COL_GROUPS = 4,
  parameter int WIN_COLS   = 640
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        desc_valid,
  output logic                        desc_ack,
  output logic                        load_desc_now,
  output logic [ROWS-1:0]             load_row,
  output logic [COL_GROUPS-1:0]       load_col_grp,
  input  logic                        win_valid,
  output logic                        win_ready,
  output logic                        load_win_reg,
  output logic                        load_acc_reg,
  output logic                        result_valid,
  output logic [$clog2(WIN_COLS)-1:0] result_idx,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 stall_cycles
);

  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = (COL_GROUPS > 1) ? $clog2(COL_GROUPS) : 1;
  localparam int IW      = $clog2(WIN_COLS);
  // A result emerges once the window has filled every PE column.
  localparam int RES_OFS = 4 * COL_GROUPS - 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DESC_WAIT  = 3'd1;
  localparam logic [2:0] DESC_LOAD  = 3'd2;
  localparam logic [2:0] WIN_STREAM = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic [IW-1:0] beat_reg;
  logic          result_valid_reg;
  logic [IW-1:0] result_idx_reg;

  logic last_word;
  logic last_beat;
  logic beat_has_result;

  assign last_word       = (row_reg == RW'(ROWS - 1)) && (col_reg == CW'(COL_GROUPS - 1));
  assign last_beat       = (beat_reg == IW'(WIN_COLS - 1));
  assign beat_has_result = (beat_reg >= IW'(RES_OFS));

  // Strobes are decoded from the registered state and the handshake input.
  assign desc_ack      = (state_reg == DESC_WAIT) && desc_valid;
  assign load_desc_now = desc_ack;
  assign win_ready     = (state_reg == WIN_STREAM);
  assign load_win_reg  = win_ready && win_valid;
  assign load_acc_reg  = load_win_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign result_valid  = result_valid_reg;
  assign result_idx    = result_idx_reg;

  // One-hot row and column-group selects are gated by the load strobe.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_dec
      assign load_row[gi] = load_desc_now && (row_reg == RW'(gi));
    end
    for (gi = 0; gi < COL_GROUPS; gi++) begin : g_col_dec
      assign load_col_grp[gi] = load_desc_now && (col_reg == CW'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (start) state_next = DESC_WAIT;
      DESC_WAIT:  if (desc_valid) state_next = DESC_LOAD;
      DESC_LOAD:  state_next = last_word ? WIN_STREAM : DESC_WAIT;
      WIN_STREAM: if (win_valid && last_beat) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      row_reg          <= '0;
      col_reg          <= '0;
      beat_reg         <= '0;
      result_valid_reg <= 1'b0;
      result_idx_reg   <= '0;
    end else begin
      state_reg <= state_next;

      case (state_reg)
        IDLE: begin
          if (start) begin
            row_reg  <= '0;
            col_reg  <= '0;
            beat_reg <= '0;
          end
        end
        DESC_LOAD: begin
          if (col_reg == CW'(COL_GROUPS - 1)) begin
            col_reg <= '0;
            row_reg <= (row_reg == RW'(ROWS - 1)) ? '0 : row_reg + RW'(1);
          end else begin
            col_reg <= col_reg + CW'(1);
          end
        end
        WIN_STREAM: begin
          if (win_valid) beat_reg <= beat_reg + IW'(1);
        end
        default: ;
      endcase

      // The result for beat b appears the cycle after b is accepted.
      result_valid_reg <= load_win_reg && beat_has_result;
      if (load_win_reg && beat_has_result)
        result_idx_reg <= beat_reg - IW'(RES_OFS);
    end
  end

`ifdef NCC_SEQ_STALL_CNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      stall_reg <= '0;
    end else if ((state_reg == WIN_STREAM) && !win_valid && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_ncc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ncc_sequencer
//
// Purpose:
//   Directed self-checking bench for ncc_sequencer at default parameters.
//   It covers reset state, abort of a pass mid-descriptor, descriptor load
//   timing and select decode, a full window stream, a stream with bubbles,
//   stray start and desc_valid inputs during streaming, and back-to-back
//   passes.
//
// Ports:
//   none (top-level bench)
// -----------------------------------------------------------------------------
module tb_ncc_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        desc_valid;
  logic        desc_ack;
  logic        load_desc_now;
  logic [15:0] load_row;
  logic [3:0]  load_col_grp;
  logic        win_valid;
  logic        win_ready;
  logic        load_win_reg;
  logic        load_acc_reg;
  logic        result_valid;
  logic [9:0]  result_idx;
  logic        busy;
  logic        done;
  logic [15:0] stall_cycles;

  int compared   = 0;
  int mismatched = 0;
  int held_idx   = 0;

  ncc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .desc_valid    (desc_valid),
    .desc_ack      (desc_ack),
    .load_desc_now (load_desc_now),
    .load_row      (load_row),
    .load_col_grp  (load_col_grp),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .load_win_reg  (load_win_reg),
    .load_acc_reg  (load_acc_reg),
    .result_valid  (result_valid),
    .result_idx    (result_idx),
    .busy          (busy),
    .done          (done),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full pass, from start through done and the IDLE cycle that follows.
  // The bubbles argument toggles win_valid 1/0. The stray argument raises
  // start and desc_valid during streaming.
  task automatic run_pass(input bit bubbles, input bit stray);
    int b;
    int cyc;
    int results;
    int pulses;
    int stalls;
    logic exp_rv;
    int exp_idx;
    int k;
    logic [31:0] exp_stall;

    start = 1'b1;
    tick();
    start      = 1'b0;
    desc_valid = 1'b1;
    // Cycle c after start: words are acknowledged on odd cycles 1..127.
    for (int c = 1; c <= 128; c++) begin
      #1;
      check("busy_desc", busy, 1);
      check("win_ready_desc", win_ready, 0);
      if (c % 2 == 1) begin
        k = (c - 1) / 2;
        check("desc_ack_on", desc_ack, 1);
        check("load_desc_now_on", load_desc_now, 1);
        check("load_row", load_row, 32'd1 << (k / 4));
        check("load_col_grp", load_col_grp, 32'd1 << (k % 4));
      end else begin
        check("desc_ack_off", desc_ack, 0);
        check("load_row_off", load_row, 0);
        check("load_col_off", load_col_grp, 0);
      end
      tick();
    end

    desc_valid = stray;
    b       = 0;
    cyc     = 0;
    results = 0;
    pulses  = 0;
    stalls  = 0;
    exp_rv  = 1'b0;
    exp_idx = held_idx;
    while (b < 640 && cyc < 3000) begin
      win_valid = bubbles ? ((cyc % 2) == 0) : 1'b1;
      start     = stray && (cyc == 5 || cyc == 300);
      #1;
      check("win_ready", win_ready, 1);
      check("load_win_reg", load_win_reg, win_valid);
      check("load_acc_reg", load_acc_reg, win_valid);
      check("desc_ack_stream", desc_ack, 0);
      check("result_valid", result_valid, exp_rv);
      check("result_idx", result_idx, exp_idx);
      check("done_stream", done, 0);
      if (result_valid) results++;
      if (load_win_reg) pulses++;
      if (win_valid) begin
        exp_rv = (b >= 15);
        if (b >= 15) exp_idx = b - 15;
        b++;
      end else begin
        exp_rv = 1'b0;
        stalls++;
      end
      tick();
      cyc++;
    end
    check("stream_beats_within_budget", b, 640);
    win_valid  = 1'b0;
    start      = 1'b0;
    desc_valid = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("busy_done", busy, 1);
    check("last_result_valid", result_valid, 1);
    check("last_result_idx", result_idx, 624);
    if (result_valid) results++;
    check("result_count", results, 625);
    check("win_pulse_count", pulses, 640);
`ifdef NCC_SEQ_STALL_CNT_EN
    exp_stall = stalls;
`else
    exp_stall = 0;
`endif
    check("stall_at_done", stall_cycles, exp_stall);
    tick();
    check("done_cleared", done, 0);
    check("busy_idle", busy, 0);
    check("result_valid_idle", result_valid, 0);
    check("result_idx_held", result_idx, 624);
    check("stall_held", stall_cycles, exp_stall);
    held_idx = 624;
    $display("pass bubbles=%0d stray=%0d: beats=%0d results=%0d stalls=%0d", bubbles, stray, b, results, stalls);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    desc_valid = 1'b0;
    win_valid  = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_desc_ack", desc_ack, 0);
    check("rst_win_ready", win_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_idx", result_idx, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_load_row", load_row, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    $display("reset state checked");

    // Abort a pass after 10 descriptor words.
    start = 1'b1;
    tick();
    start      = 1'b0;
    desc_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("abort_ack", desc_ack, 1);
      check("abort_row", load_row, 32'd1 << (k / 4));
      check("abort_col", load_col_grp, 32'd1 << (k % 4));
      tick();
      tick();
    end
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_desc_ack", desc_ack, 0);
    check("abort_load_desc_now", load_desc_now, 0);
    check("abort_load_row", load_row, 0);
    check("abort_win_reg", load_win_reg, 0);
    check("abort_done", done, 0);
    rst        = 1'b0;
    desc_valid = 1'b0;
    tick();
    $display("mid-descriptor reset checked");

    // Full pass after the abort: the descriptor restarts at row 0, col 0.
    run_pass(1'b0, 1'b0);
    // Back-to-back with bubbles; start lands on the cycle after done.
    run_pass(1'b1, 1'b0);
    // Back-to-back with stray start and desc_valid during the stream.
    run_pass(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
